// File: rtl/serial_sub_sequencer.sv
// -----------------------------------------------------------------------------
// serial_sub_sequencer
//   Bit-serial subtract controller. Computes oDiff = iA - iB for WIDTH-bit
//   operands by feeding one bit pair per cycle (LSB first) and the running
//   borrow into an external combinational full subtracter. It collects that
//   stage's diff/borrow bits and assembles the result.
//
// Ports
//   iClk, iRst_n        clock (rising edge), asynchronous active-low reset
//   iStart              start request, honoured only in IDLE or DONE
//   iA, iB              minuend / subtrahend, captured on an accepted start
//   oBitA, oBitB, oBitC operand bits and borrow-in to the full subtracter
//   iBitDiff, iBitBorrow full subtracter diff / borrow-out, same cycle
//   oBusy               high while bits are being shifted
//   oDone               one-cycle pulse when oDiff/oBorrow become valid
//   oDiff, oBorrow      result and final borrow, held until the next result
// -----------------------------------------------------------------------------
module serial_sub_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBitA,
  output logic             oBitB,
  output logic             oBitC,
  input  logic             iBitDiff,
  input  logic             iBitBorrow,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oDiff,
  output logic             oBorrow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic               borrow_q, borrow_d;
  logic               accept;
  logic [WIDTH-1:0]   res_shift;

  // Result accumulates MSB-first from the right-shifting side: after WIDTH
  // shifts the first (LSB) diff bit has reached bit 0.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = iBitDiff;
  end else begin : g_res_wn
    assign res_shift = {iBitDiff, res_q[WIDTH-1:1]};
  end

  // A new start is only honoured when no operation is in flight.
  assign accept = iStart && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;

    case (state_q)
      ST_IDLE: begin
        if (iStart) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        res_d  = res_shift;
        brw_d  = iBitBorrow;
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          // Capture the final stage directly so the result includes the
          // bit being consumed on this edge.
          diff_d   = res_shift;
          borrow_d = iBitBorrow;
        end
      end
      ST_DONE: begin
        state_d = iStart ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      sh_a_d = iA;
      sh_b_d = iB;
      brw_d  = 1'b0;
      cnt_d  = '0;
      res_d  = '0;
    end
  end

  assign oBusy   = (state_q == ST_SHIFT);
  assign oDone   = (state_q == ST_DONE);
  assign oBitA   = oBusy & sh_a_q[0];
  assign oBitB   = oBusy & sh_b_q[0];
  assign oBitC   = oBusy & brw_q;
  assign oDiff   = diff_q;
  assign oBorrow = borrow_q;

endmodule
